// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with whole-scan debounce
module keypad_scanner #(
  parameter int SCAN_TICKS     = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2, COL3 = 2'd3} col_state_t;

  col_state_t    state;
  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic [4:0]    prev_res;
  logic [4:0]    deb_state;
  logic [SW-1:0] stable_count;

  logic          samp_hit;
  logic [1:0]    samp_row;
  logic [3:0]    samp_code;
  logic [4:0]    scan_res;
  logic [SW-1:0] stable_next;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: keymap = 4'h1;
      4'b00_01: keymap = 4'h2;
      4'b00_10: keymap = 4'h3;
      4'b00_11: keymap = 4'hA;
      4'b01_00: keymap = 4'h4;
      4'b01_01: keymap = 4'h5;
      4'b01_10: keymap = 4'h6;
      4'b01_11: keymap = 4'hB;
      4'b10_00: keymap = 4'h7;
      4'b10_01: keymap = 4'h8;
      4'b10_10: keymap = 4'h9;
      4'b10_11: keymap = 4'hC;
      4'b11_00: keymap = 4'h0;
      4'b11_01: keymap = 4'hF;
      4'b11_10: keymap = 4'hE;
      default:  keymap = 4'hD;
    endcase
  endfunction

  // Rows are asynchronous to clk
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + CW'(1);
  end

  assign tick = (tick_cnt == CW'(SCAN_TICKS - 1));

  always_comb begin
    samp_hit  = ~&row_s2;
    samp_row  = 2'd3;
    if      (!row_s2[0]) samp_row = 2'd0;
    else if (!row_s2[1]) samp_row = 2'd1;
    else if (!row_s2[2]) samp_row = 2'd2;
    samp_code = keymap(samp_row, state);
    // No-hit results are normalised to all zeros so they compare equal
    if (acc_hit)       scan_res = {1'b1, acc_code};
    else if (samp_hit) scan_res = {1'b1, samp_code};
    else               scan_res = 5'b0;
    if (scan_res != prev_res)                       stable_next = SW'(1);
    else if (stable_count == SW'(DEBOUNCE_SCANS))   stable_next = stable_count;
    else                                            stable_next = stable_count + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COL0;
      col          <= 4'b1110;
      acc_hit      <= 1'b0;
      acc_code     <= 4'h0;
      prev_res     <= 5'b0;
      deb_state    <= 5'b0;
      stable_count <= '0;
      key_code     <= 4'h0;
      key_valid    <= 1'b0;
      key_pressed  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          COL0:    begin state <= COL1; col <= 4'b1101; end
          COL1:    begin state <= COL2; col <= 4'b1011; end
          COL2:    begin state <= COL3; col <= 4'b0111; end
          default: begin state <= COL0; col <= 4'b1110; end
        endcase
        if (state == COL3) begin
          acc_hit      <= 1'b0;
          acc_code     <= 4'h0;
          prev_res     <= scan_res;
          stable_count <= stable_next;
          if (stable_next == SW'(DEBOUNCE_SCANS) && scan_res != deb_state) begin
            deb_state <= scan_res;
            if (scan_res[4]) begin
              key_code    <= scan_res[3:0];
              key_pressed <= 1'b1;
              key_valid   <= 1'b1;
            end else begin
              key_pressed <= 1'b0;
            end
          end
        end else if (!acc_hit && samp_hit) begin
          acc_hit  <= 1'b1;
          acc_code <= samp_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a 4x4 keypad model
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] held;   // bit r*4+c set while key (r,c) is held
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pulses = 0;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col[c]) row[r] = 1'b0;
    end
  end

  localparam int K1 = 0*4+0, K5 = 1*4+1, K9 = 2*4+2, K7 = 2*4+0, KA = 0*4+3, KD = 3*4+3;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    logic [3:0] e;
    held  = '0;
    reset = 1'b1;
    step();
    step();
    check("reset_col", {4'h0, col}, 8'h0E);
    check("reset_code", {4'h0, key_code}, 8'h00);
    check("reset_valid", {7'h0, key_valid}, 8'h00);
    check("reset_pressed", {7'h0, key_pressed}, 8'h00);
    reset = 1'b0;
    cyc   = 0;

    for (int k = 0; k < 32; k++) begin
      run_to(k);
      e = 4'b0001 << ((k / 4) % 4);
      check("col_seq", {4'h0, col}, {4'h0, ~e});
    end
    run_to(64);
    check("idle_pulses", pulses[7:0], 8'd0);
    check("idle_pressed", {7'h0, key_pressed}, 8'h00);

    // Hold '5' from scan 4
    held[K5] = 1'b1;
    run_to(95);
    check("k5_early", {7'h0, key_valid}, 8'h00);
    step();
    check("k5_valid", {7'h0, key_valid}, 8'h01);
    check("k5_code", {4'h0, key_code}, 8'h05);
    check("k5_pressed", {7'h0, key_pressed}, 8'h01);
    step();
    check("k5_one_cycle", {7'h0, key_valid}, 8'h00);
    run_to(256);
    check("k5_no_repeat", pulses[7:0], 8'd1);
    check("k5_held", {7'h0, key_pressed}, 8'h01);

    // Release '5' at scan 16
    held = '0;
    run_to(287);
    check("rel_before", {7'h0, key_pressed}, 8'h01);
    step();
    check("rel_pressed", {7'h0, key_pressed}, 8'h00);
    check("rel_code", {4'h0, key_code}, 8'h05);
    run_to(304);
    check("rel_no_strobe", pulses[7:0], 8'd1);

    // 'A' toggled every scan never settles
    for (int i = 0; i < 8; i++) begin
      held = '0;
      if (i % 2 == 0) held[KA] = 1'b1;
      run_to(304 + 16 * (i + 1));
      check("toggle_pressed", {7'h0, key_pressed}, 8'h00);
    end
    check("toggle_pulses", pulses[7:0], 8'd1);

    // '1' and 'D' together: lowest column wins
    held = '0;
    held[K1] = 1'b1;
    held[KD] = 1'b1;
    run_to(463);
    check("k1_early", {7'h0, key_valid}, 8'h00);
    step();
    check("k1_valid", {7'h0, key_valid}, 8'h01);
    check("k1_code", {4'h0, key_code}, 8'h01);

    // Roll over to '9' while 'D' stays down
    held[K1] = 1'b0;
    held[K9] = 1'b1;
    run_to(480);
    check("roll_pressed", {7'h0, key_pressed}, 8'h01);
    run_to(495);
    check("k9_early", {7'h0, key_valid}, 8'h00);
    step();
    check("k9_valid", {7'h0, key_valid}, 8'h01);
    check("k9_code", {4'h0, key_code}, 8'h09);
    check("k9_pressed", {7'h0, key_pressed}, 8'h01);

    // Debounce '7', then reset mid-scan while it is held
    held = '0;
    held[K7] = 1'b1;
    run_to(528);
    check("k7_code", {4'h0, key_code}, 8'h07);
    check("k7_pulses", pulses[7:0], 8'd4);
    run_to(536);
    reset = 1'b1;
    step();
    check("rst_pressed", {7'h0, key_pressed}, 8'h00);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_code", {4'h0, key_code}, 8'h00);
    reset = 1'b0;
    cyc   = 0;
    run_to(31);
    check("k7r_early", {7'h0, key_valid}, 8'h00);
    step();
    check("k7r_valid", {7'h0, key_valid}, 8'h01);
    check("k7r_code", {4'h0, key_code}, 8'h07);
    check("k7r_pressed", {7'h0, key_pressed}, 8'h01);
    run_to(80);
    check("total_pulses", pulses[7:0], 8'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
